// File: rtl/ram_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_seq_ctrl_if
//  Description : Command, sample and RAM-port bundle for the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 9
);
    logic                  en;
    logic                  rec_start;
    logic                  play_start;
    logic                  echo_start;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] len;
    logic [DATA_WIDTH-1:0] sample_in;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] sample_out;
    logic                  sample_valid;
    logic [1:0]            state;
    logic                  rec_done;
    logic                  has_rec;

    // Sequencer side
    modport slave (
        input  en, rec_start, play_start, echo_start, stop, len, sample_in, ram_dout,
        output wr_en, rd_en, wr_addr, rd_addr, din, sample_out, sample_valid,
               state, rec_done, has_rec
    );

    // Environment side: command source, sample source, RAM and output path
    modport master (
        output en, rec_start, play_start, echo_start, stop, len, sample_in, ram_dout,
        input  wr_en, rd_en, wr_addr, rd_addr, din, sample_out, sample_valid,
               state, rec_done, has_rec
    );
endinterface
`default_nettype wire

// File: rtl/ram_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_seq_ctrl
//  Description : Record / playback / echo sequencer for a simple dual-port
//                sample RAM with one access slot per sample tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_seq_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 9
) (
    input  logic         clk,
    input  logic         rst,
    ram_seq_ctrl_if.slave bus
);

    localparam logic [1:0] c_st_idle   = 2'b00;
    localparam logic [1:0] c_st_record = 2'b01;
    localparam logic [1:0] c_st_play   = 2'b10;
    localparam logic [1:0] c_st_echo   = 2'b11;

    localparam logic [ADDR_WIDTH:0]   c_depth    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one  = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH-1:0] r_lat_len;
    logic [ADDR_WIDTH-1:0] r_stored_len;
    logic                  r_has_rec;
    logic                  r_rec_done;
    logic                  r_sample_valid;

    logic                  w_tick;
    logic [ADDR_WIDTH:0]   w_delay;
    logic                  w_fill_done;
    logic                  w_rec_last;
    logic                  w_play_last;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_echo_rd_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic [DATA_WIDTH-1:0] w_sample_out;

    // A tick that coincides with stop or reset never reaches the RAM.
    assign w_tick = bus.en && !bus.stop && !rst;

    // A latched length of zero stands for the full RAM depth.
    assign w_delay     = (r_lat_len == '0) ? c_depth : {1'b0, r_lat_len};
    assign w_fill_done = (r_cnt >= w_delay);

    // Length-minus-one wraps to all-ones for the zero (full-depth) encoding.
    assign w_rec_last  = (r_cnt[ADDR_WIDTH-1:0] == (r_lat_len - c_addr_one));
    assign w_play_last = (r_rd_ptr == (r_stored_len - c_addr_one));

    assign w_echo_rd_addr = r_wr_ptr - r_lat_len;

    assign w_wr_en = w_tick && ((r_state == c_st_record) || (r_state == c_st_echo));
    assign w_rd_en = w_tick && ((r_state == c_st_play) ||
                                ((r_state == c_st_echo) && w_fill_done));

    assign w_din        = bus.sample_in;
    assign w_sample_out = bus.ram_dout;

    assign bus.wr_en        = w_wr_en;
    assign bus.rd_en        = w_rd_en;
    assign bus.wr_addr      = r_wr_ptr;
    assign bus.rd_addr      = (r_state == c_st_play) ? r_rd_ptr : w_echo_rd_addr;
    assign bus.din          = w_din;
    assign bus.sample_out   = w_sample_out;
    assign bus.sample_valid = r_sample_valid;
    assign bus.state        = r_state;
    assign bus.rec_done     = r_rec_done;
    assign bus.has_rec      = r_has_rec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_cnt          <= '0;
            r_lat_len      <= '0;
            r_stored_len   <= '0;
            r_has_rec      <= 1'b0;
            r_rec_done     <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_rec_done     <= 1'b0;
            r_sample_valid <= w_rd_en;

            if (bus.stop) begin
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (bus.rec_start) begin
                            r_state   <= c_st_record;
                            r_wr_ptr  <= '0;
                            r_cnt     <= '0;
                            r_lat_len <= bus.len;
                            r_has_rec <= 1'b0;
                        end else if (bus.play_start && r_has_rec) begin
                            r_state  <= c_st_play;
                            r_rd_ptr <= '0;
                        end else if (bus.echo_start) begin
                            r_state   <= c_st_echo;
                            r_wr_ptr  <= '0;
                            r_cnt     <= '0;
                            r_lat_len <= bus.len;
                        end
                    end

                    c_st_record: begin
                        if (bus.en) begin
                            r_wr_ptr <= r_wr_ptr + c_addr_one;
                            r_cnt    <= r_cnt + c_cnt_one;
                            if (w_rec_last) begin
                                r_state      <= c_st_idle;
                                r_has_rec    <= 1'b1;
                                r_stored_len <= r_lat_len;
                                r_rec_done   <= 1'b1;
                            end
                        end
                    end

                    c_st_play: begin
                        if (bus.en) begin
                            r_rd_ptr <= w_play_last ? '0 : (r_rd_ptr + c_addr_one);
                        end
                    end

                    c_st_echo: begin
                        if (bus.en) begin
                            r_wr_ptr <= r_wr_ptr + c_addr_one;
                            // Fill counter saturates once the delay line is primed.
                            if (!w_fill_done) begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end
                    end

                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ram_seq_ctrl
//  Description : Scoreboard bench for ram_seq_ctrl with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_seq_ctrl;

    localparam int c_aw    = 9;
    localparam int c_dw    = 9;
    localparam int c_depth = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_seq_ctrl_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) bus ();

    ram_seq_ctrl #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 512x9 RAM: sync write, registered read, read-during-write returns old data
    logic [c_dw-1:0] r_mem [c_depth];
    always @(posedge clk) begin
        if (bus.rd_en) bus.ram_dout <= r_mem[bus.rd_addr];
        if (bus.wr_en) r_mem[bus.wr_addr] <= bus.din;
    end

    int              n_checks = 0;
    int              n_fails  = 0;
    logic [c_dw-1:0] sb_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b1; bus.rec_start = 1'b0; bus.play_start = 1'b0;
        bus.echo_start = 1'b0; bus.stop = 1'b0; bus.len = '0; bus.sample_in = '0;
        step(); step();
        @(negedge clk);
        n_checks++;
        if (bus.state !== 2'b00 || bus.has_rec !== 1'b0 || bus.rec_done !== 1'b0 ||
            bus.sample_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_regs: state=%b has_rec=%b rec_done=%b valid=%b, want 00 0 0 0",
                     bus.state, bus.has_rec, bus.rec_done, bus.sample_valid);
        end
        rst = 1'b0;
        step();
        @(negedge clk);
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.state !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_idle_access: wr_en=%b rd_en=%b state=%b, want 0 0 00",
                     bus.wr_en, bus.rd_en, bus.state);
        end
    endtask

    task automatic test_play_no_rec();
        step();
        bus.play_start = 1'b1;
        step();
        bus.play_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00) begin
            n_fails++;
            $display("FAIL play_no_rec_state: state=%b, want 00", bus.state);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_en !== 1'b0 || bus.sample_valid !== 1'b0) begin
                n_fails++;
                $display("FAIL play_no_rec_read: rd_en=%b valid=%b, want 0 0",
                         bus.rd_en, bus.sample_valid);
            end
            step();
        end
    endtask

    task automatic test_record();
        bus.len = 9'd4; bus.rec_start = 1'b1; bus.en = 1'b1;
        step();
        bus.rec_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b01) begin
            n_fails++;
            $display("FAIL rec_enter: state=%b, want 01", bus.state);
        end
        for (int k = 0; k < 4; k++) begin
            bus.sample_in = c_dw'(10 + k);
            @(negedge clk);
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== c_aw'(k) || bus.rd_en !== 1'b0) begin
                n_fails++;
                $display("FAIL rec_write: wr_en=%b wr_addr=%0d rd_en=%b, want 1 %0d 0",
                         bus.wr_en, bus.wr_addr, bus.rd_en, k);
            end
            step();
        end
        n_checks++;
        if (bus.state !== 2'b00 || bus.has_rec !== 1'b1 || bus.rec_done !== 1'b1) begin
            n_fails++;
            $display("FAIL rec_complete: state=%b has_rec=%b rec_done=%b, want 00 1 1",
                     bus.state, bus.has_rec, bus.rec_done);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.rec_done !== 1'b0 || bus.wr_en !== 1'b0) begin
            n_fails++;
            $display("FAIL rec_done_pulse: rec_done=%b wr_en=%b, want 0 0", bus.rec_done, bus.wr_en);
        end
    endtask

    task automatic test_stop_priority();
        step();
        bus.stop = 1'b1; bus.rec_start = 1'b1;
        step();
        bus.stop = 1'b0; bus.rec_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || bus.has_rec !== 1'b1) begin
            n_fails++;
            $display("FAIL stop_priority: state=%b has_rec=%b, want 00 1", bus.state, bus.has_rec);
        end
    endtask

    task automatic test_play();
        int              exp_addr = 0;
        logic            prev_rd  = 1'b0;
        logic [c_dw-1:0] exp;
        sb_q.delete();
        bus.play_start = 1'b1; bus.en = 1'b0;
        step();
        bus.play_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b10) begin
            n_fails++;
            $display("FAIL play_enter: state=%b, want 10", bus.state);
        end
        for (int c = 0; c < 39; c++) begin
            bus.en = (c % 2 == 0);
            @(negedge clk);
            n_checks++;
            if (bus.sample_valid !== prev_rd) begin
                n_fails++;
                $display("FAIL play_valid: valid=%b, want %b (cycle %0d)", bus.sample_valid, prev_rd, c);
            end
            if (bus.sample_valid === 1'b1 && sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                n_checks++;
                if (bus.sample_out !== exp) begin
                    n_fails++;
                    $display("FAIL play_data: sample_out=%0d, want %0d", bus.sample_out, exp);
                end
            end
            n_checks++;
            if (bus.rd_en !== bus.en || (bus.en && bus.rd_addr !== c_aw'(exp_addr))) begin
                n_fails++;
                $display("FAIL play_read: rd_en=%b rd_addr=%0d, want %b %0d",
                         bus.rd_en, bus.rd_addr, bus.en, exp_addr);
            end
            if (bus.en) begin
                sb_q.push_back(c_dw'(10 + exp_addr));
                exp_addr = (exp_addr + 1) % 4;
            end
            prev_rd = bus.en;
            step();
        end
        // Stop right after a read: that read must still deliver its sample
        bus.stop = 1'b1; bus.en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rd_en !== 1'b0 || bus.sample_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL play_stop_cycle: rd_en=%b valid=%b, want 0 1", bus.rd_en, bus.sample_valid);
        end
        if (bus.sample_valid === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_checks++;
            if (bus.sample_out !== exp) begin
                n_fails++;
                $display("FAIL play_last_data: sample_out=%0d, want %0d", bus.sample_out, exp);
            end
        end
        step();
        bus.stop = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 2'b00 || bus.sample_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL play_stopped: state=%b valid=%b pending=%0d, want 00 0 0",
                     bus.state, bus.sample_valid, sb_q.size());
        end
    endtask

    task automatic test_echo(input int d_len, input int n_ticks);
        int              delay   = (d_len == 0) ? c_depth : d_len;
        logic            prev_rd = 1'b0;
        logic            exp_rd;
        logic [c_dw-1:0] exp;
        sb_q.delete();
        step();
        bus.len = c_aw'(d_len); bus.echo_start = 1'b1; bus.en = 1'b1;
        step();
        bus.echo_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b11) begin
            n_fails++;
            $display("FAIL echo_enter: state=%b, want 11 (len %0d)", bus.state, d_len);
        end
        for (int t = 0; t < n_ticks; t++) begin
            bus.sample_in = c_dw'((t + 1) % c_depth);
            @(negedge clk);
            n_checks++;
            if (bus.sample_valid !== prev_rd) begin
                n_fails++;
                $display("FAIL echo_valid: valid=%b, want %b (len %0d tick %0d)",
                         bus.sample_valid, prev_rd, d_len, t);
            end
            if (bus.sample_valid === 1'b1 && sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                n_checks++;
                if (bus.sample_out !== exp) begin
                    n_fails++;
                    $display("FAIL echo_data: sample_out=%0d, want %0d (len %0d tick %0d)",
                             bus.sample_out, exp, d_len, t);
                end
            end
            exp_rd = (t >= delay);
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== c_aw'(t % c_depth) || bus.rd_en !== exp_rd ||
                (exp_rd && bus.rd_addr !== c_aw'((t - delay) % c_depth))) begin
                n_fails++;
                $display("FAIL echo_access: wr_en=%b wr_addr=%0d rd_en=%b rd_addr=%0d, want 1 %0d %b %0d",
                         bus.wr_en, bus.wr_addr, bus.rd_en, bus.rd_addr, t % c_depth, exp_rd,
                         (t - delay + c_depth) % c_depth);
            end
            if (exp_rd) sb_q.push_back(c_dw'((t - delay + 1) % c_depth));
            prev_rd = exp_rd;
            step();
        end
        bus.stop = 1'b1;
        @(negedge clk);
        if (bus.sample_valid === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_checks++;
            if (bus.sample_out !== exp) begin
                n_fails++;
                $display("FAIL echo_last_data: sample_out=%0d, want %0d", bus.sample_out, exp);
            end
        end
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0) begin
            n_fails++;
            $display("FAIL echo_stop_access: wr_en=%b rd_en=%b, want 0 0", bus.wr_en, bus.rd_en);
        end
        step();
        bus.stop = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL echo_stopped: state=%b pending=%0d, want 00 0", bus.state, sb_q.size());
        end
    endtask

    task automatic test_record_full();
        int              k       = 0;
        int              c       = 0;
        int              exp_addr = 0;
        logic            prev_rd = 1'b0;
        logic [c_dw-1:0] exp;
        step();
        bus.len = '0; bus.rec_start = 1'b1; bus.en = 1'b1;
        step();
        bus.rec_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b01 || bus.has_rec !== 1'b0) begin
            n_fails++;
            $display("FAIL full_enter: state=%b has_rec=%b, want 01 0", bus.state, bus.has_rec);
        end
        while (k < c_depth) begin
            bus.en = (c % 7 != 6);
            bus.sample_in = c_dw'(k ^ 'h155);
            @(negedge clk);
            n_checks++;
            if (bus.wr_en !== bus.en || (bus.en && bus.wr_addr !== c_aw'(k))) begin
                n_fails++;
                $display("FAIL full_write: wr_en=%b wr_addr=%0d, want %b %0d", bus.wr_en, bus.wr_addr, bus.en, k);
            end
            if (bus.en) k++;
            c++;
            step();
        end
        n_checks++;
        if (bus.state !== 2'b00 || bus.has_rec !== 1'b1 || bus.rec_done !== 1'b1) begin
            n_fails++;
            $display("FAIL full_complete: state=%b has_rec=%b rec_done=%b, want 00 1 1",
                     bus.state, bus.has_rec, bus.rec_done);
        end
        sb_q.delete();
        bus.en = 1'b1; bus.play_start = 1'b1;
        step();
        bus.play_start = 1'b0;
        for (int n = 0; n < c_depth + 3; n++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sample_valid !== prev_rd) begin
                n_fails++;
                $display("FAIL full_play_valid: valid=%b, want %b", bus.sample_valid, prev_rd);
            end
            if (bus.sample_valid === 1'b1 && sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                n_checks++;
                if (bus.sample_out !== exp) begin
                    n_fails++;
                    $display("FAIL full_play_data: sample_out=%0d, want %0d", bus.sample_out, exp);
                end
            end
            n_checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr !== c_aw'(exp_addr)) begin
                n_fails++;
                $display("FAIL full_play_read: rd_en=%b rd_addr=%0d, want 1 %0d", bus.rd_en, bus.rd_addr, exp_addr);
            end
            sb_q.push_back(c_dw'(exp_addr ^ 'h155));
            exp_addr = (exp_addr + 1) % c_depth;
            prev_rd = 1'b1;
            step();
        end
        bus.stop = 1'b1;
        @(negedge clk);
        if (bus.sample_valid === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_checks++;
            if (bus.sample_out !== exp) begin
                n_fails++;
                $display("FAIL full_play_last: sample_out=%0d, want %0d", bus.sample_out, exp);
            end
        end
        step();
        bus.stop = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL full_play_stopped: state=%b pending=%0d, want 00 0", bus.state, sb_q.size());
        end
    endtask

    task automatic test_abort_and_rst();
        step();
        bus.len = 9'd8; bus.rec_start = 1'b1; bus.en = 1'b1;
        step();
        bus.rec_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b01 || bus.has_rec !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_enter: state=%b has_rec=%b, want 01 0", bus.state, bus.has_rec);
        end
        for (int k = 0; k < 3; k++) begin
            bus.sample_in = c_dw'(k);
            step();
        end
        bus.stop = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.wr_en !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_stop_write: wr_en=%b, want 0", bus.wr_en);
        end
        step();
        bus.stop = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || bus.has_rec !== 1'b0 || bus.rec_done !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_result: state=%b has_rec=%b rec_done=%b, want 00 0 0",
                     bus.state, bus.has_rec, bus.rec_done);
        end
        bus.play_start = 1'b1;
        step();
        bus.play_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || bus.rec_done !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_play_refused: state=%b rec_done=%b, want 00 0", bus.state, bus.rec_done);
        end
        // Fresh two-sample recording, then reset in the middle of playback
        bus.len = 9'd2; bus.rec_start = 1'b1;
        step();
        bus.rec_start = 1'b0;
        step(); step();
        bus.play_start = 1'b1;
        step();
        bus.play_start = 1'b0;
        n_checks++;
        if (bus.state !== 2'b10) begin
            n_fails++;
            $display("FAIL rst_play_enter: state=%b, want 10", bus.state);
        end
        step(); step(); step();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rd_en !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_cycle_read: rd_en=%b, want 0", bus.rd_en);
        end
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || bus.has_rec !== 1'b0 || bus.sample_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_mid_play: state=%b has_rec=%b valid=%b, want 00 0 0",
                     bus.state, bus.has_rec, bus.sample_valid);
        end
        sb_q.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.sample_valid !== 1'b0) begin
                n_fails++;
                $display("FAIL rst_after_access: rd_en=%b wr_en=%b valid=%b, want 0 0 0",
                         bus.rd_en, bus.wr_en, bus.sample_valid);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_play_no_rec();
        test_record();
        test_stop_priority();
        test_play();
        test_echo(3, 20);
        test_echo(0, 520);
        test_record_full();
        test_abort_and_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
